rrat_recovery_ctrl: RTL and testbench
=====================================

# rrat_recovery_ctrl

Sequences architectural-state recovery after a retiring mispredicted branch. It triggers the RRAT rollback read and captures the committed map. It then restores the front-end RAT over several cycles, a few entries per cycle, and finishes by rebuilding the free list from the set of physical tags still mapped. It sits between the ROB retire stage, the RRAT, the RAT write-restore port and the free list, and stalls retire and dispatch while recovery is in progress.

## Interface
- SCALAR, 2, retire width
- NUM_ARCH, 32, architectural registers (RRAT/RAT entries)
- NUM_PREG, 64, physical registers
- ARCH_IDX_WIDTH, 5, clog2(NUM_ARCH)
- PREG_IDX_WIDTH, 6, clog2(NUM_PREG)
- COPY_PER_CYCLE, 4, RAT restore writes per cycle; NUM_ARCH % COPY_PER_CYCLE must be 0 (elaboration-time check)

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- mispredict_in  in  1  retiring branch in this cycle was mispredicted
- rrat_rollback  out  1  drives RRAT rollback; RRAT copy is valid only while this is high
- rrat_copy_tag  in  NUM_ARCH×PREG_IDX_WIDTH  RRAT copy output (already includes same-cycle retire writes)
- rat_restore_en  out  COPY_PER_CYCLE  per-lane RAT write enable
- rat_restore_addr  out  COPY_PER_CYCLE×ARCH_IDX_WIDTH  arch index per lane
- rat_restore_tag  out  COPY_PER_CYCLE×PREG_IDX_WIDTH  physical tag per lane
- freelist_load_en  out  1  one-cycle pulse: free list replaces its state with freelist_mask
- freelist_mask  out  NUM_PREG  1 = physical register free
- flush_out  out  1  one-cycle pipeline flush pulse
- retire_stall  out  1  ROB must not retire
- dispatch_stall  out  1  front end must not dispatch/rename

## Operation
- FSM states: IDLE, COPY, FREE.
- IDLE: rrat_rollback = mispredict_in. On mispredict_in, register all of rrat_copy_tag into an internal snapshot, clear the used-bitmap and the chunk counter, and go to COPY.
- COPY: chunk counter c runs from 0 to NUM_ARCH/COPY_PER_CYCLE−1. Lane k drives en=1, addr=c·COPY_PER_CYCLE+k and tag=snapshot[addr]. Each lane's tag bit is set in the used-bitmap. Go to FREE after the last chunk.
- FREE: freelist_load_en=1 and freelist_mask = ~(used | written-this-cycle). This equals ~used, because the bitmap is complete after COPY. Go to IDLE.
- flush_out pulses in the first COPY cycle only.
- retire_stall = dispatch_stall = (state≠IDLE) | mispredict_in.
- mispredict_in outside IDLE is ignored, and rrat_rollback stays 0. The ROB cannot assert it because retire_stall is high. The testbench asserts that it never occurs.
- Duplicate tags in the snapshot are legal. The bitmap is an OR, so the mask stays correct.
- All outputs not listed as active in a state are 0.

## Timing
- Reset: state=IDLE, counter=0, snapshot=0, used=0. Every output is 0 at reset except rrat_rollback and the stalls, which follow mispredict_in combinationally.
- Mispredict at cycle T is captured at the edge ending T.
- Restore writes occupy T+1 … T+N, where N = NUM_ARCH/COPY_PER_CYCLE (8 by default). flush_out is at T+1.
- freelist_load_en is at T+N+1. The FSM is IDLE at T+N+2, with stalls low unless a new mispredict arrives.
- Total stall cycles = N+2 including T.
- Reset asserted mid-recovery aborts at the next edge. The FSM goes to IDLE, with no further restore writes and no freelist load.
- All control outputs except rrat_rollback and the stalls are registered-state decodes, with no dependence on mispredict_in.

## Structure
- A shared package (the rename/maptable package) holds the state enum `rrat_rec_state_t`. It also holds the derived constant NUM_CHUNKS and a `rat_restore_lane_t` struct {en, addr, tag}.
- Natural sub-module: `preg_used_bitmap`. It provides clear, a COPY_PER_CYCLE-wide set port with tag decode, and exposes the bitmap.
- The remaining logic is the FSM, the chunk counter, the snapshot register and the lane muxing.

## Test plan
- Reset, then the identity RRAT (tag i at arch i) with mispredict at T → restore writes addr 0–3 with tags 0–3 at T+1 … addr 28–31 with tags 28–31 at T+8. freelist_mask = 64'hFFFF_FFFF_0000_0000 at T+9. Stalls high T … T+9, low at T+10.
- RRAT with arch i → tag i+32 → freelist_mask = 64'h0000_0000_FFFF_FFFF. flush_out high only at T+1.
- All arch entries map to tag 5 → every restore tag is 5 and freelist_mask has only bit 5 cleared.
- mispredict_in held high for 3 cycles → exactly one recovery, rrat_rollback high only at T, with no second capture.
- Reset asserted at T+4 → no restore enable from T+5 onward, freelist_load_en never pulses, and IDLE holds with stalls low.
- Back-to-back recoveries, the second mispredict at T+10 → the second sequence starts cleanly and its mask reflects only the second snapshot, not the first.

Source files
------------

// File: rtl/rrat_recovery_ctrl_pkg.sv
// Shared rename/maptable definitions for the RRAT-driven recovery sequencer:
// state encoding, default geometry, derived chunk count and the restore-lane record.
package rrat_recovery_ctrl_pkg;

  localparam int RREC_NUM_ARCH       = 32;
  localparam int RREC_NUM_PREG       = 64;
  localparam int RREC_ARCH_IDX_WIDTH = 5;
  localparam int RREC_PREG_IDX_WIDTH = 6;
  localparam int RREC_COPY_PER_CYCLE = 4;
  localparam int NUM_CHUNKS          = RREC_NUM_ARCH / RREC_COPY_PER_CYCLE;

  localparam logic [1:0] RREC_IDLE = 2'd0;
  localparam logic [1:0] RREC_COPY = 2'd1;
  localparam logic [1:0] RREC_FREE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = RREC_IDLE,
    ST_COPY = RREC_COPY,
    ST_FREE = RREC_FREE
  } rrat_rec_state_t;

  typedef struct packed {
    logic                           en;
    logic [RREC_ARCH_IDX_WIDTH-1:0] addr;
    logic [RREC_PREG_IDX_WIDTH-1:0] tag;
  } rat_restore_lane_t;

endpackage

// File: rtl/preg_used_bitmap.sv
// Tracks which physical tags are still mapped while the RAT is being restored;
// several tags may be marked per cycle and duplicates simply OR together.
module preg_used_bitmap #(
  parameter int NUM_PREG       = 64,
  parameter int PREG_IDX_WIDTH = 6,
  parameter int SET_PORTS      = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                clear,
  input  logic [SET_PORTS-1:0]                set_en,
  input  logic [SET_PORTS*PREG_IDX_WIDTH-1:0] set_tag,
  output logic [NUM_PREG-1:0]                 set_vec,
  output logic [NUM_PREG-1:0]                 used
);

  localparam logic [NUM_PREG-1:0] ONE_HOT_LSB = {{(NUM_PREG-1){1'b0}}, 1'b1};

  logic [NUM_PREG-1:0] set_vec_s;
  logic [NUM_PREG-1:0] used_r;

  // Decode every enabled set port into a one-hot and merge them.
  always_comb begin
    set_vec_s = {NUM_PREG{1'b0}};
    for (int k = 0; k < SET_PORTS; k++) begin
      set_vec_s = set_vec_s |
                  (set_en[k] ? (ONE_HOT_LSB << set_tag[k*PREG_IDX_WIDTH +: PREG_IDX_WIDTH])
                             : {NUM_PREG{1'b0}});
    end
  end

  // Bitmap storage: clear at the start of a recovery, accumulate during restore.
  always_ff @(posedge clock) begin
    if (reset) begin
      used_r <= {NUM_PREG{1'b0}};
    end else if (clear) begin
      used_r <= {NUM_PREG{1'b0}};
    end else begin
      used_r <= used_r | set_vec_s;
    end
  end

  assign set_vec = set_vec_s;
  assign used    = used_r;

endmodule

// File: rtl/rrat_recovery_ctrl.sv
// Mispredict recovery sequencer: snapshots the RRAT, replays it into the RAT a chunk
// per cycle, then reloads the free list with every tag not referenced by the snapshot.
module rrat_recovery_ctrl
  import rrat_recovery_ctrl_pkg::*;
#(
  parameter int SCALAR         = 2,
  parameter int NUM_ARCH       = RREC_NUM_ARCH,
  parameter int NUM_PREG       = RREC_NUM_PREG,
  parameter int ARCH_IDX_WIDTH = RREC_ARCH_IDX_WIDTH,
  parameter int PREG_IDX_WIDTH = RREC_PREG_IDX_WIDTH,
  parameter int COPY_PER_CYCLE = RREC_COPY_PER_CYCLE
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic                                     mispredict_in,
  output logic                                     rrat_rollback,
  input  logic [NUM_ARCH*PREG_IDX_WIDTH-1:0]       rrat_copy_tag,
  output logic [COPY_PER_CYCLE-1:0]                rat_restore_en,
  output logic [COPY_PER_CYCLE*ARCH_IDX_WIDTH-1:0] rat_restore_addr,
  output logic [COPY_PER_CYCLE*PREG_IDX_WIDTH-1:0] rat_restore_tag,
  output logic                                     freelist_load_en,
  output logic [NUM_PREG-1:0]                      freelist_mask,
  output logic                                     flush_out,
  output logic                                     retire_stall,
  output logic                                     dispatch_stall
);

  localparam int CHUNKS = NUM_ARCH / COPY_PER_CYCLE;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

  // Geometry must divide evenly and agree with the shared lane record.
  if ((NUM_ARCH % COPY_PER_CYCLE) != 0) begin : g_bad_chunking
    $error("NUM_ARCH must be a multiple of COPY_PER_CYCLE");
  end
  if ((ARCH_IDX_WIDTH != RREC_ARCH_IDX_WIDTH) || (PREG_IDX_WIDTH != RREC_PREG_IDX_WIDTH) ||
      (CHUNKS != NUM_CHUNKS) || (SCALAR < 1)) begin : g_bad_geometry
    $error("rrat_recovery_ctrl geometry disagrees with rrat_recovery_ctrl_pkg");
  end

  rrat_rec_state_t                     state_r;
  logic [CNT_W-1:0]                    chunk_r;
  logic [NUM_ARCH*PREG_IDX_WIDTH-1:0]  snapshot_r;
  rat_restore_lane_t                   lane_s [COPY_PER_CYCLE];
  logic                                copying_s;
  logic                                start_s;
  logic [NUM_PREG-1:0]                 used_s;
  logic [NUM_PREG-1:0]                 set_vec_s;

  assign start_s        = (state_r == ST_IDLE) & mispredict_in;
  assign copying_s      = (state_r == ST_COPY);
  assign rrat_rollback  = start_s;
  assign retire_stall   = (state_r != ST_IDLE) | mispredict_in;
  assign dispatch_stall = (state_r != ST_IDLE) | mispredict_in;

  // Recovery FSM, chunk counter and RRAT snapshot capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      chunk_r    <= CNT_ZERO;
      snapshot_r <= {(NUM_ARCH*PREG_IDX_WIDTH){1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mispredict_in) begin
            snapshot_r <= rrat_copy_tag;
            chunk_r    <= CNT_ZERO;
            state_r    <= ST_COPY;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_COPY: begin
          if (chunk_r == LAST_CHUNK) begin
            chunk_r <= CNT_ZERO;
            state_r <= ST_FREE;
          end else begin
            chunk_r <= chunk_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_FREE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          chunk_r <= CNT_ZERO;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Lane k of chunk c restores arch entry c*COPY_PER_CYCLE+k from the snapshot.
  always_comb begin
    for (int k = 0; k < COPY_PER_CYCLE; k++) begin
      lane_s[k].en   = copying_s;
      lane_s[k].addr = copying_s ? ARCH_IDX_WIDTH'(int'(chunk_r) * COPY_PER_CYCLE + k)
                                 : {ARCH_IDX_WIDTH{1'b0}};
      lane_s[k].tag  = copying_s ? snapshot_r[int'(lane_s[k].addr)*PREG_IDX_WIDTH +: PREG_IDX_WIDTH]
                                 : {PREG_IDX_WIDTH{1'b0}};
    end
  end

  for (genvar g = 0; g < COPY_PER_CYCLE; g++) begin : g_lane_pack
    assign rat_restore_en[g]                                    = lane_s[g].en;
    assign rat_restore_addr[g*ARCH_IDX_WIDTH +: ARCH_IDX_WIDTH] = lane_s[g].addr;
    assign rat_restore_tag[g*PREG_IDX_WIDTH +: PREG_IDX_WIDTH]  = lane_s[g].tag;
  end

  preg_used_bitmap #(
    .NUM_PREG       (NUM_PREG),
    .PREG_IDX_WIDTH (PREG_IDX_WIDTH),
    .SET_PORTS      (COPY_PER_CYCLE)
  ) u_used_bitmap (
    .clock   (clock),
    .reset   (reset),
    .clear   (start_s),
    .set_en  (rat_restore_en),
    .set_tag (rat_restore_tag),
    .set_vec (set_vec_s),
    .used    (used_s)
  );

  assign flush_out        = copying_s & (chunk_r == CNT_ZERO);
  assign freelist_load_en = (state_r == ST_FREE);
  assign freelist_mask    = (state_r == ST_FREE) ? ~(used_s | set_vec_s) : {NUM_PREG{1'b0}};

endmodule

// File: tb/tb_rrat_recovery_ctrl.sv
// Directed bench for rrat_recovery_ctrl: walks full recoveries for several RRAT images,
// a held mispredict, a mid-recovery reset and back-to-back recoveries.
module tb_rrat_recovery_ctrl;

  logic         clock;
  logic         reset;
  logic         mispredict_in;
  logic         rrat_rollback;
  logic [191:0] rrat_copy_tag;
  logic [3:0]   rat_restore_en;
  logic [19:0]  rat_restore_addr;
  logic [23:0]  rat_restore_tag;
  logic         freelist_load_en;
  logic [63:0]  freelist_mask;
  logic         flush_out;
  logic         retire_stall;
  logic         dispatch_stall;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_map [32];

  rrat_recovery_ctrl dut (
    .clock            (clock),
    .reset            (reset),
    .mispredict_in    (mispredict_in),
    .rrat_rollback    (rrat_rollback),
    .rrat_copy_tag    (rrat_copy_tag),
    .rat_restore_en   (rat_restore_en),
    .rat_restore_addr (rat_restore_addr),
    .rat_restore_tag  (rat_restore_tag),
    .freelist_load_en (freelist_load_en),
    .freelist_mask    (freelist_mask),
    .flush_out        (flush_out),
    .retire_stall     (retire_stall),
    .dispatch_stall   (dispatch_stall)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: arch i -> tag i; mode 1: arch i -> tag i+32; mode 2: every arch -> tag 5
  task automatic set_map(input int mode);
    for (int i = 0; i < 32; i++) begin
      case (mode)
        0:       exp_map[i] = 6'(i);
        1:       exp_map[i] = 6'(i + 32);
        default: exp_map[i] = 6'd5;
      endcase
      rrat_copy_tag[i*6 +: 6] = exp_map[i];
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_check(input string nm);
    #3;
    chk({nm, "_retire_stall"},   64'(retire_stall),     64'd0);
    chk({nm, "_dispatch_stall"}, 64'(dispatch_stall),   64'd0);
    chk({nm, "_rollback"},       64'(rrat_rollback),    64'd0);
    chk({nm, "_en"},             64'(rat_restore_en),   64'd0);
    chk({nm, "_load"},           64'(freelist_load_en), 64'd0);
    chk({nm, "_mask"},           freelist_mask,         64'd0);
    chk({nm, "_flush"},          64'(flush_out),        64'd0);
    next_cycle();
  endtask

  // Starts at the beginning of cycle T, ends at the beginning of cycle T+10.
  // hold>1 keeps mispredict_in high for that many cycles and scrambles the RRAT copy
  // afterwards so any late recapture shows up in the restore tags.
  task automatic run_recovery(input string nm, input int hold, input logic [63:0] exp_mask);
    logic [19:0] exp_addr;
    logic [23:0] exp_tag;
    mispredict_in = 1'b1;
    #3;
    chk({nm, "_T_rollback"}, 64'(rrat_rollback),    64'd1);
    chk({nm, "_T_stall"},    64'(retire_stall),     64'd1);
    chk({nm, "_T_dstall"},   64'(dispatch_stall),   64'd1);
    chk({nm, "_T_en"},       64'(rat_restore_en),   64'd0);
    chk({nm, "_T_flush"},    64'(flush_out),        64'd0);
    chk({nm, "_T_load"},     64'(freelist_load_en), 64'd0);
    next_cycle();
    mispredict_in = (hold > 1);
    if (hold > 1) rrat_copy_tag = ~rrat_copy_tag;
    for (int c = 0; c < 8; c++) begin
      for (int k = 0; k < 4; k++) begin
        exp_addr[k*5 +: 5] = 5'(c*4 + k);
        exp_tag[k*6 +: 6]  = exp_map[c*4 + k];
      end
      #3;
      chk($sformatf("%s_c%0d_en", nm, c),       64'(rat_restore_en),   64'hF);
      chk($sformatf("%s_c%0d_addr", nm, c),     64'(rat_restore_addr), 64'(exp_addr));
      chk($sformatf("%s_c%0d_tag", nm, c),      64'(rat_restore_tag),  64'(exp_tag));
      chk($sformatf("%s_c%0d_flush", nm, c),    64'(flush_out),        (c == 0) ? 64'd1 : 64'd0);
      chk($sformatf("%s_c%0d_load", nm, c),     64'(freelist_load_en), 64'd0);
      chk($sformatf("%s_c%0d_rollback", nm, c), 64'(rrat_rollback),    64'd0);
      chk($sformatf("%s_c%0d_stall", nm, c),    64'(retire_stall),     64'd1);
      next_cycle();
      mispredict_in = (c + 2 < hold);
    end
    #3;
    chk({nm, "_free_load"},  64'(freelist_load_en), 64'd1);
    chk({nm, "_free_mask"},  freelist_mask,         exp_mask);
    chk({nm, "_free_en"},    64'(rat_restore_en),   64'd0);
    chk({nm, "_free_flush"}, 64'(flush_out),        64'd0);
    chk({nm, "_free_stall"}, 64'(retire_stall),     64'd1);
    chk({nm, "_free_dstall"},64'(dispatch_stall),   64'd1);
    next_cycle();
  endtask

  initial begin
    reset         = 1'b1;
    mispredict_in = 1'b0;
    rrat_copy_tag = 192'd0;
    next_cycle();
    next_cycle();
    #3;
    chk("rst_en",       64'(rat_restore_en),   64'd0);
    chk("rst_load",     64'(freelist_load_en), 64'd0);
    chk("rst_mask",     freelist_mask,         64'd0);
    chk("rst_flush",    64'(flush_out),        64'd0);
    chk("rst_rollback", 64'(rrat_rollback),    64'd0);
    chk("rst_stall",    64'(retire_stall),     64'd0);
    next_cycle();
    mispredict_in = 1'b1;
    #3;
    chk("rst_mp_rollback", 64'(rrat_rollback),  64'd1);
    chk("rst_mp_stall",    64'(retire_stall),   64'd1);
    chk("rst_mp_dstall",   64'(dispatch_stall), 64'd1);
    chk("rst_mp_en",       64'(rat_restore_en), 64'd0);
    next_cycle();
    mispredict_in = 1'b0;
    reset         = 1'b0;
    idle_check("post_rst");

    set_map(0);
    run_recovery("ident", 1, 64'hFFFF_FFFF_0000_0000);
    idle_check("ident_idle");

    set_map(1);
    run_recovery("upper", 1, 64'h0000_0000_FFFF_FFFF);
    idle_check("upper_idle");

    set_map(2);
    run_recovery("dup5", 1, 64'hFFFF_FFFF_FFFF_FFDF);
    idle_check("dup5_idle");

    set_map(0);
    run_recovery("hold3", 3, 64'hFFFF_FFFF_0000_0000);
    idle_check("hold3_idle");

    // Reset lands during T+4; recovery must abort at the edge ending T+4.
    set_map(1);
    mispredict_in = 1'b1;
    next_cycle();
    mispredict_in = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    #3;
    chk("abort_T4_en", 64'(rat_restore_en), 64'hF);
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #3;
      chk($sformatf("abort_%0d_en", i),    64'(rat_restore_en),   64'd0);
      chk($sformatf("abort_%0d_load", i),  64'(freelist_load_en), 64'd0);
      chk($sformatf("abort_%0d_stall", i), 64'(retire_stall),     64'd0);
      chk($sformatf("abort_%0d_flush", i), 64'(flush_out),        64'd0);
      next_cycle();
    end

    set_map(0);
    run_recovery("b2b_first", 1, 64'hFFFF_FFFF_0000_0000);
    set_map(1);
    run_recovery("b2b_second", 1, 64'h0000_0000_FFFF_FFFF);
    idle_check("b2b_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
